// File: rtl/seven_segment_mux.sv
// Time-multiplexed seven-segment driver: shadow/active digit registers, per-slot
// anti-ghosting guard, optional hex glyphs, leading-zero blanking and polarity select.
module seven_segment_mux #(
  parameter int NUM_DIGITS     = 2,
  parameter int REFRESH_DIV    = 25000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit HEX_MODE       = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [4*NUM_DIGITS-1:0]   i_nums,
  input  logic                      i_load,
  input  logic                      i_blank_lz,
  output logic [6:0]                o_seg,
  output logic [NUM_DIGITS-1:0]     o_dig_en
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0]         CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [CW:0]           GUARD_LEN = (CW + 1)'(BLANK_CYCLES);
  localparam logic [6:0]            SEG_POL   = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_POL   = {NUM_DIGITS{SEG_ACTIVE_LOW}};

  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [DW-1:0]         shadow_reg, shadow_next;
  logic [DW-1:0]         active_reg, active_next;
  logic [6:0]            seg_reg, seg_next;
  logic [NUM_DIGITS-1:0] dig_en_reg, dig_en_next;

  logic                  slot_end;
  logic                  guard;
  logic [3:0]            code_sel;
  logic [NUM_DIGITS-1:0] digit_zero;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  zero_run;
  logic [6:0]            seg_ah;
  logic [NUM_DIGITS-1:0] dig_ah;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    g = 7'h00;
    case (code)
      4'd0:  g = 7'h7E;
      4'd1:  g = 7'h30;
      4'd2:  g = 7'h6D;
      4'd3:  g = 7'h79;
      4'd4:  g = 7'h33;
      4'd5:  g = 7'h5B;
      4'd6:  g = 7'h5F;
      4'd7:  g = 7'h70;
      4'd8:  g = 7'h7F;
      4'd9:  g = 7'h7B;
      4'd10: g = HEX_MODE ? 7'h77 : 7'h00;
      4'd11: g = HEX_MODE ? 7'h1F : 7'h00;
      4'd12: g = HEX_MODE ? 7'h4E : 7'h00;
      4'd13: g = HEX_MODE ? 7'h3D : 7'h00;
      4'd14: g = HEX_MODE ? 7'h4F : 7'h00;
      4'd15: g = HEX_MODE ? 7'h47 : 7'h00;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  assign slot_end = (cnt_reg == CNT_LAST);

  // A load in the boundary cycle reaches the active register directly via shadow_next.
  always_comb begin
    cnt_next    = slot_end ? '0 : cnt_reg + 1'b1;
    idx_next    = idx_reg;
    if (slot_end) begin
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
    shadow_next = i_load ? i_nums : shadow_reg;
    active_next = slot_end ? shadow_next : active_reg;
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
      assign digit_zero[gi] = (active_next[4*gi +: 4] == 4'd0);
    end
  endgenerate

  // lz_blank[k]: digit k and every digit above it are zero; digit 0 is never blanked.
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run & digit_zero[k];
      lz_blank[k] = zero_run;
    end
  end

  assign code_sel = active_next[{idx_next, 2'b00} +: 4];

  // Outputs are computed from next-state values so enable and segments flip on the same edge.
  always_comb begin
    guard  = ({1'b0, cnt_next} < GUARD_LEN);
    seg_ah = 7'h00;
    dig_ah = '0;
    if (!guard) begin
      dig_ah[idx_next] = 1'b1;
      if (!(i_blank_lz && lz_blank[idx_next])) begin
        seg_ah = glyph(code_sel);
      end
    end
    seg_next    = seg_ah ^ SEG_POL;
    dig_en_next = dig_ah ^ DIG_POL;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg    <= '0;
      idx_reg    <= '0;
      shadow_reg <= '0;
      active_reg <= '0;
      seg_reg    <= SEG_POL;
      dig_en_reg <= DIG_POL;
    end else begin
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      shadow_reg <= shadow_next;
      active_reg <= active_next;
      seg_reg    <= seg_next;
      dig_en_reg <= dig_en_next;
    end
  end

  assign o_seg    = seg_reg;
  assign o_dig_en = dig_en_reg;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Scoreboard bench for seven_segment_mux: three instances (decimal, hex, hex active-low)
// share stimulus; a cycle model pushes expected outputs that each test pops and compares.
module tb_seven_segment_mux;

  logic       clk;
  logic       rst_n;
  logic [7:0] nums;
  logic       load;
  logic       blank_lz;
  logic [6:0] seg0, seg1, seg2;
  logic [1:0] dig0, dig1, dig2;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0] dig;
    logic [6:0] s0;
    logic [6:0] s1;
  } exp_t;

  exp_t sb[$];

  logic [1:0] m_cnt;
  logic       m_idx;
  logic [7:0] m_shadow;
  logic [7:0] m_active;

  seven_segment_mux #(.NUM_DIGITS(2), .REFRESH_DIV(4), .BLANK_CYCLES(1),
                      .SEG_ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) u_dec (
    .i_clk(clk), .i_rst_n(rst_n), .i_nums(nums), .i_load(load),
    .i_blank_lz(blank_lz), .o_seg(seg0), .o_dig_en(dig0));

  seven_segment_mux #(.NUM_DIGITS(2), .REFRESH_DIV(4), .BLANK_CYCLES(1),
                      .SEG_ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) u_hex (
    .i_clk(clk), .i_rst_n(rst_n), .i_nums(nums), .i_load(load),
    .i_blank_lz(blank_lz), .o_seg(seg1), .o_dig_en(dig1));

  seven_segment_mux #(.NUM_DIGITS(2), .REFRESH_DIV(4), .BLANK_CYCLES(1),
                      .SEG_ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)) u_inv (
    .i_clk(clk), .i_rst_n(rst_n), .i_nums(nums), .i_load(load),
    .i_blank_lz(blank_lz), .o_seg(seg2), .o_dig_en(dig2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] c, input bit hex);
    case (c)
      4'd0: return 7'h7E;  4'd1: return 7'h30;  4'd2: return 7'h6D;  4'd3: return 7'h79;
      4'd4: return 7'h33;  4'd5: return 7'h5B;  4'd6: return 7'h5F;  4'd7: return 7'h70;
      4'd8: return 7'h7F;  4'd9: return 7'h7B;
      4'd10: return hex ? 7'h77 : 7'h00;
      4'd11: return hex ? 7'h1F : 7'h00;
      4'd12: return hex ? 7'h4E : 7'h00;
      4'd13: return hex ? 7'h3D : 7'h00;
      4'd14: return hex ? 7'h4F : 7'h00;
      default: return hex ? 7'h47 : 7'h00;
    endcase
  endfunction

  // Slot-level model: 4-cycle slot, cycle 0 of each slot is the guard cycle.
  always @(posedge clk) begin : model
    logic [1:0] c_n;
    logic       i_n;
    logic [7:0] a_n;
    logic [3:0] code;
    logic       off;
    logic       lzb;
    exp_t       e;
    e = '0;
    if (!rst_n) begin
      m_cnt    <= 2'd0;
      m_idx    <= 1'b0;
      m_shadow <= 8'h00;
      m_active <= 8'h00;
    end else begin
      c_n  = (m_cnt == 2'd3) ? 2'd0 : m_cnt + 2'd1;
      i_n  = (m_cnt == 2'd3) ? ~m_idx : m_idx;
      a_n  = (m_cnt == 2'd3) ? (load ? nums : m_shadow) : m_active;
      code = i_n ? a_n[7:4] : a_n[3:0];
      off  = (c_n == 2'd0);
      lzb  = blank_lz && i_n && (a_n[7:4] == 4'd0);
      e.dig = off ? 2'b00 : (i_n ? 2'b10 : 2'b01);
      e.s0  = (off || lzb) ? 7'h00 : glyph(code, 1'b0);
      e.s1  = (off || lzb) ? 7'h00 : glyph(code, 1'b1);
      m_cnt    <= c_n;
      m_idx    <= i_n;
      m_active <= a_n;
      if (load) m_shadow <= nums;
    end
    sb.push_back(e);
  end

  task automatic align(input logic [1:0] target);
    for (int k = 0; k < 8 && m_cnt !== target; k++) @(negedge clk);
    if (m_cnt !== target) begin
      checks++;
      errors++;
      $display("FAIL align: model counter %0d, required %0d", m_cnt, target);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    logic [1:0] want;
    rst_n = 1'b0; load = 1'b0; nums = 8'h00; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dig0, seg0, dig2, seg2} !== {2'b00, 7'h00, 2'b11, 7'h7F}) begin
      errors++;
      $display("FAIL reset_state: got dig0=%b seg0=%h dig2=%b seg2=%h, required 00/00 11/7f",
               dig0, seg0, dig2, seg2);
    end
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL reset_seq: scoreboard empty at cycle %0d", i);
      end else begin
        e = sb.pop_front();
        if ({dig0, seg0} !== {e.dig, e.s0} || {dig1, seg1} !== {e.dig, e.s1} ||
            {dig2, seg2} !== {~e.dig, ~e.s1}) begin
          errors++;
          $display("FAIL reset_seq cyc=%0d: got %b/%h %b/%h %b/%h, required %b/%h/%h",
                   i, dig0, seg0, dig1, seg1, dig2, seg2, e.dig, e.s0, e.s1);
        end
      end
      want = (i % 4 == 3) ? 2'b00 : (((i / 4) % 2 == 1) ? 2'b10 : 2'b01);
      checks++;
      if (dig0 !== want || (want != 2'b00 && seg0 !== 7'h7E)) begin
        errors++;
        $display("FAIL idle_pattern cyc=%0d: got dig=%b seg=%h, required dig=%b seg=7e",
                 i, dig0, seg0, want);
      end
    end
    $display("test_reset: done, errors=%0d", errors);
  endtask

  task automatic test_load_mid();
    exp_t e;
    align(2'd1);
    nums = 8'h42; load = 1'b1;
    sb.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      load = 1'b0;
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL load_mid: scoreboard empty at cycle %0d", i);
      end else begin
        e = sb.pop_front();
        if ({dig0, seg0} !== {e.dig, e.s0} || {dig1, seg1} !== {e.dig, e.s1} ||
            {dig2, seg2} !== {~e.dig, ~e.s1}) begin
          errors++;
          $display("FAIL load_mid cyc=%0d: got %b/%h %b/%h %b/%h, required %b/%h/%h",
                   i, dig0, seg0, dig1, seg1, dig2, seg2, e.dig, e.s0, e.s1);
        end
      end
      if (i < 2) begin
        checks++;
        if (seg0 !== 7'h7E) begin
          errors++; $display("FAIL load_mid_hold cyc=%0d: got seg=%h, required 7e", i, seg0);
        end
      end else if (i > 2 && dig0 != 2'b00) begin
        checks++;
        if (seg0 !== ((dig0 == 2'b01) ? 7'h6D : 7'h33)) begin
          errors++;
          $display("FAIL load_mid_value cyc=%0d: got dig=%b seg=%h", i, dig0, seg0);
        end
      end
    end
    $display("test_load_mid: done, errors=%0d", errors);
  endtask

  task automatic test_load_boundary();
    exp_t e;
    align(2'd3);
    nums = 8'h19; load = 1'b1;
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load = 1'b0;
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL load_boundary: scoreboard empty at cycle %0d", i);
      end else begin
        e = sb.pop_front();
        if ({dig0, seg0} !== {e.dig, e.s0} || {dig1, seg1} !== {e.dig, e.s1} ||
            {dig2, seg2} !== {~e.dig, ~e.s1}) begin
          errors++;
          $display("FAIL load_boundary cyc=%0d: got %b/%h %b/%h %b/%h, required %b/%h/%h",
                   i, dig0, seg0, dig1, seg1, dig2, seg2, e.dig, e.s0, e.s1);
        end
      end
      if (i >= 1 && i <= 3) begin
        checks++;
        if (dig0 == 2'b00 || seg0 !== ((dig0 == 2'b01) ? 7'h7B : 7'h30)) begin
          errors++;
          $display("FAIL bypass cyc=%0d: got dig=%b seg=%h, required new value 19", i, dig0, seg0);
        end
      end
    end
    $display("test_load_boundary: done, errors=%0d", errors);
  endtask

  task automatic test_blank_lz();
    exp_t e;
    nums = 8'h07; load = 1'b1; blank_lz = 1'b0;
    sb.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      load = 1'b0;
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL blank_lz: scoreboard empty at cycle %0d", i);
      end else begin
        e = sb.pop_front();
        if ({dig0, seg0} !== {e.dig, e.s0} || {dig1, seg1} !== {e.dig, e.s1} ||
            {dig2, seg2} !== {~e.dig, ~e.s1}) begin
          errors++;
          $display("FAIL blank_lz cyc=%0d: got %b/%h %b/%h %b/%h, required %b/%h/%h",
                   i, dig0, seg0, dig1, seg1, dig2, seg2, e.dig, e.s0, e.s1);
        end
      end
      if (i >= 6 && dig0 != 2'b00) begin
        checks++;
        if (seg0 !== ((dig0 == 2'b01) ? 7'h70 : (blank_lz ? 7'h00 : 7'h7E))) begin
          errors++;
          $display("FAIL lz_value cyc=%0d blank=%0d: got dig=%b seg=%h", i, blank_lz, dig0, seg0);
        end
      end
      blank_lz = ((i / 3) % 2 == 1);
    end
    blank_lz = 1'b0;
    $display("test_blank_lz: done, errors=%0d", errors);
  endtask

  task automatic test_hex();
    exp_t e;
    nums = 8'hAF; load = 1'b1;
    sb.delete();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      load = 1'b0;
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL hex: scoreboard empty at cycle %0d", i);
      end else begin
        e = sb.pop_front();
        if ({dig0, seg0} !== {e.dig, e.s0} || {dig1, seg1} !== {e.dig, e.s1} ||
            {dig2, seg2} !== {~e.dig, ~e.s1}) begin
          errors++;
          $display("FAIL hex cyc=%0d: got %b/%h %b/%h %b/%h, required %b/%h/%h",
                   i, dig0, seg0, dig1, seg1, dig2, seg2, e.dig, e.s0, e.s1);
        end
      end
      if (i >= 6 && dig0 != 2'b00) begin
        checks++;
        if (seg0 !== 7'h00 || seg1 !== ((dig0 == 2'b01) ? 7'h47 : 7'h77) ||
            seg2 !== ~seg1 || dig2 !== ~dig0) begin
          errors++;
          $display("FAIL hex_value cyc=%0d: got dig=%b seg0=%h seg1=%h dig2=%b seg2=%h",
                   i, dig0, seg0, seg1, dig2, seg2);
        end
      end
    end
    $display("test_hex: done, errors=%0d", errors);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sb.delete();
    for (int i = 0; i < 48; i++) begin
      load     = ($urandom_range(0, 2) != 0);
      nums     = 8'($urandom);
      blank_lz = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL back_to_back: scoreboard empty at cycle %0d", i);
      end else begin
        e = sb.pop_front();
        if ({dig0, seg0} !== {e.dig, e.s0} || {dig1, seg1} !== {e.dig, e.s1} ||
            {dig2, seg2} !== {~e.dig, ~e.s1}) begin
          errors++;
          $display("FAIL back_to_back cyc=%0d: got %b/%h %b/%h %b/%h, required %b/%h/%h",
                   i, dig0, seg0, dig1, seg1, dig2, seg2, e.dig, e.s0, e.s1);
        end
      end
    end
    load = 1'b0; blank_lz = 1'b0;
    $display("test_back_to_back: done, errors=%0d", errors);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    align(2'd1);
    nums = 8'h55; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dig0, seg0, dig1, seg1, dig2, seg2} !== {2'b00, 7'h00, 2'b00, 7'h00, 2'b11, 7'h7F}) begin
      errors++;
      $display("FAIL reset_mid_off: got %b/%h %b/%h %b/%h, required 00/00 00/00 11/7f",
               dig0, seg0, dig1, seg1, dig2, seg2);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL reset_mid: scoreboard empty at cycle %0d", i);
      end else begin
        e = sb.pop_front();
        if ({dig0, seg0} !== {e.dig, e.s0} || {dig1, seg1} !== {e.dig, e.s1} ||
            {dig2, seg2} !== {~e.dig, ~e.s1}) begin
          errors++;
          $display("FAIL reset_mid cyc=%0d: got %b/%h %b/%h %b/%h, required %b/%h/%h",
                   i, dig0, seg0, dig1, seg1, dig2, seg2, e.dig, e.s0, e.s1);
        end
      end
      if (dig0 != 2'b00) begin
        checks++;
        if (seg0 !== 7'h7E) begin
          errors++;
          $display("FAIL reset_discard cyc=%0d: got seg=%h, required 7e", i, seg0);
        end
      end
    end
    $display("test_reset_mid: done, errors=%0d", errors);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; nums = 8'h00; blank_lz = 1'b0;
    test_reset();
    test_load_mid();
    test_load_boundary();
    test_blank_lz();
    test_hex();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_mux.md
SEVEN_SEGMENT_MUX -- requirements
Module: seven_segment_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 25000: clocks per digit slot, minimum 2.
REQ-003 SHALL have parameter BLANK_CYCLES, default 16: all-digits-off guard at the start of each slot (anti-ghosting); legal range 0..REFRESH_DIV-1.
REQ-004 SHALL have parameter SEG_ACTIVE_LOW, default 0: 1 inverts o_seg and o_dig_en polarity.
REQ-005 SHALL have parameter HEX_MODE, default 0: 0 blanks codes 10-15; 1 shows A,b,C,d,E,F.
REQ-006 SHALL have port i_clk  input  1  single system clock; all state on its rising edge.
REQ-007 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port i_nums  input  4*NUM_DIGITS  digit codes; bits [3:0] are digit 0 (least significant).
REQ-009 SHALL have port i_load  input  1  capture i_nums into the shadow register.
REQ-010 SHALL have port i_blank_lz  input  1  enable leading-zero blanking.
REQ-011 SHALL have port o_seg  output  7  segments; bit6=A down to bit0=G.
REQ-012 SHALL have port o_dig_en  output  NUM_DIGITS  one-hot digit enable.

Function
REQ-013 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; the wrap cycle is the slot boundary.
REQ-014 Digit index SHALL increment at each slot boundary, wrapping NUM_DIGITS-1 -> 0; NUM_DIGITS=1 holds index 0.
REQ-015 Within a slot, o_dig_en SHALL be all-off for the first BLANK_CYCLES cycles, then one-hot at the index for the remaining REFRESH_DIV-BLANK_CYCLES cycles.
REQ-016 o_seg and o_dig_en SHALL be registered, change only on rising i_clk, and switch together so no cycle shows a new digit enable with old segments.
REQ-017 i_load high SHALL write i_nums into the shadow register on that edge; repeated loads within a slot keep the last value.
REQ-018 The active register SHALL copy the shadow at each slot boundary, so the displayed value never changes mid-slot.
REQ-019 If i_load is high in the boundary cycle, the active register SHALL take i_nums directly (bypass), i.e. the new value shows from the next slot.
REQ-020 Glyph table (active-high, A..G): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B; HEX_MODE=1: A=77 b=1F C=4E d=3D E=4F F=47; HEX_MODE=0: codes 10-15 -> 00.
REQ-021 With i_blank_lz high, every digit above the highest nonzero active digit SHALL output 00; digit 0 SHALL never be blanked; all-zero value shows a single "0".
REQ-022 i_blank_lz SHALL be sampled per cycle (no latching); o_seg during guard cycles SHALL be 00 (all-off).
REQ-023 With SEG_ACTIVE_LOW=1, o_seg and o_dig_en SHALL be the bitwise inverse of the active-high values, including reset and guard values.

Reset
REQ-024 While i_rst_n is low: counter=0, index=0, shadow=0, active=0, o_seg=all-off, o_dig_en=all-off (polarity-adjusted).
REQ-025 After release, slot 0 SHALL start at counter 0, index 0, showing active value 0 after BLANK_CYCLES cycles.
REQ-026 Reset asserted mid-slot SHALL force outputs off immediately (asynchronously), discarding pending loads.

Verification (NUM_DIGITS=2, REFRESH_DIV=4, BLANK_CYCLES=1 unless stated)
REQ-027 Reset release, no load -> per 4-cycle slot: 1 cycle o_dig_en=00, 3 cycles o_dig_en alternating 01/10 by slot, o_seg=7E.
REQ-028 Load i_nums=8'h42 mid-slot -> current slot unchanged; from next boundary digit0 shows 6D, digit1 shows 33.
REQ-029 Load exactly in the boundary cycle -> new value visible in the immediately following slot (bypass).
REQ-030 i_nums=8'h07, i_blank_lz=1 -> digit1 o_seg=00, digit0=70; i_blank_lz=0 -> digit1=7E.
REQ-031 i_nums=8'hAF: HEX_MODE=0 -> both 00; HEX_MODE=1 -> digit0=47, digit1=77; SEG_ACTIVE_LOW=1 -> inverted segments and enables.
REQ-032 Assert i_rst_n low mid-slot after a load -> outputs off same cycle; after release display shows 0, not the loaded value.
